// File: rtl/bilinear_interp_pipe_if.sv
// Sample, config and result bus of the bilinear interpolator.
interface bilinear_interp_pipe_if #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned R_W    = 3,
    parameter int unsigned ANG_W  = 2
);
    logic                   s_valid;
    logic                   s_ready;
    logic [R_W-1:0]         s_r;
    logic [ANG_W-1:0]       s_angle;
    logic [PIX_W-1:0]       s_a;
    logic [PIX_W-1:0]       s_b;
    logic [PIX_W-1:0]       s_c;
    logic [PIX_W-1:0]       s_d;

    logic                   cfg_we;
    logic [R_W+ANG_W-1:0]   cfg_addr;
    logic [FRAC_W-1:0]      cfg_dx;
    logic [FRAC_W-1:0]      cfg_dy;

    logic                   m_valid;
    logic                   m_ready;
    logic [PIX_W-1:0]       m_pix;
    logic                   m_zero;

    modport slave (
        input  s_valid, s_r, s_angle, s_a, s_b, s_c, s_d,
        input  cfg_we, cfg_addr, cfg_dx, cfg_dy,
        input  m_ready,
        output s_ready, m_valid, m_pix, m_zero
    );

    modport master (
        output s_valid, s_r, s_angle, s_a, s_b, s_c, s_d,
        output cfg_we, cfg_addr, cfg_dx, cfg_dy,
        output m_ready,
        input  s_ready, m_valid, m_pix, m_zero
    );
endinterface

// File: rtl/bilinear_interp_pipe.sv
// Three-stage bilinear interpolator with a programmable {r, angle} -> {dx, dy} table.
module bilinear_interp_pipe #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned R_W    = 3,
    parameter int unsigned ANG_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    bilinear_interp_pipe_if.slave bus
);
    localparam int unsigned ADDR_W = R_W + ANG_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned ODX_W  = FRAC_W + 1;
    localparam int unsigned WGT_W  = 2 * FRAC_W + 2;
    localparam int unsigned SUM_W  = PIX_W + 2 * FRAC_W + 2;

    localparam logic [ODX_W-1:0] ONE     = ODX_W'(1) << FRAC_W;
    localparam logic [SUM_W-1:0] HALF    = SUM_W'(1) << (2 * FRAC_W - 1);
    localparam logic [SUM_W-1:0] PIX_MAX = SUM_W'({PIX_W{1'b1}});

    logic                w_en;
    logic [ADDR_W-1:0]   w_addr;

    logic [FRAC_W-1:0]   r_dx_tab [DEPTH];
    logic [FRAC_W-1:0]   r_dy_tab [DEPTH];

    logic                r_s1_vld;
    logic [PIX_W-1:0]    r_s1_a, r_s1_b, r_s1_c, r_s1_d;
    logic [FRAC_W-1:0]   r_s1_dx, r_s1_dy;

    logic [ODX_W-1:0]    w_odx, w_ody;
    logic [WGT_W-1:0]    w_wa, w_wb, w_wc, w_wd;

    logic                r_s2_vld;
    logic [PIX_W-1:0]    r_s2_a, r_s2_b, r_s2_c, r_s2_d;
    logic [WGT_W-1:0]    r_wa, r_wb, r_wc, r_wd;

    logic [SUM_W-1:0]    w_sum, w_rnd, w_res;
    logic [PIX_W-1:0]    w_pix;

    logic                r_m_valid;
    logic [PIX_W-1:0]    r_m_pix;
    logic                r_m_zero;

    assign w_en         = ~r_m_valid | bus.m_ready;
    assign w_addr       = {bus.s_r, bus.s_angle};
    assign bus.s_ready  = w_en;
    assign bus.m_valid  = r_m_valid;
    assign bus.m_pix    = r_m_pix;
    assign bus.m_zero   = r_m_zero;

    // Offset table: written whenever cfg_we is high, regardless of stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_dx_tab[ADDR_W'(i)] <= '0;
                r_dy_tab[ADDR_W'(i)] <= '0;
            end
        end else if (bus.cfg_we) begin
            r_dx_tab[bus.cfg_addr] <= bus.cfg_dx;
            r_dy_tab[bus.cfg_addr] <= bus.cfg_dy;
        end
    end

    // S1: capture corner pixels and the table entry as it stood before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_c   <= '0;
            r_s1_d   <= '0;
            r_s1_dx  <= '0;
            r_s1_dy  <= '0;
        end else if (w_en) begin
            r_s1_vld <= bus.s_valid;
            if (bus.s_valid) begin
                r_s1_a  <= bus.s_a;
                r_s1_b  <= bus.s_b;
                r_s1_c  <= bus.s_c;
                r_s1_d  <= bus.s_d;
                r_s1_dx <= r_dx_tab[w_addr];
                r_s1_dy <= r_dy_tab[w_addr];
            end
        end
    end

    // Complementary offsets and the four corner weights (they sum to 2^(2*FRAC_W)).
    always_comb begin
        w_odx = ONE - ODX_W'(r_s1_dx);
        w_ody = ONE - ODX_W'(r_s1_dy);
        w_wa  = WGT_W'(w_odx)   * WGT_W'(w_ody);
        w_wb  = WGT_W'(r_s1_dx) * WGT_W'(w_ody);
        w_wc  = WGT_W'(w_odx)   * WGT_W'(r_s1_dy);
        w_wd  = WGT_W'(r_s1_dx) * WGT_W'(r_s1_dy);
    end

    // S2: register weights alongside the pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_s2_a   <= '0;
            r_s2_b   <= '0;
            r_s2_c   <= '0;
            r_s2_d   <= '0;
            r_wa     <= '0;
            r_wb     <= '0;
            r_wc     <= '0;
            r_wd     <= '0;
        end else if (w_en) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_a <= r_s1_a;
                r_s2_b <= r_s1_b;
                r_s2_c <= r_s1_c;
                r_s2_d <= r_s1_d;
                r_wa   <= w_wa;
                r_wb   <= w_wb;
                r_wc   <= w_wc;
                r_wd   <= w_wd;
            end
        end
    end

    // Full-precision weighted sum, round half up, clamp to pixel range.
    always_comb begin
        w_sum = SUM_W'(r_wa) * SUM_W'(r_s2_a) + SUM_W'(r_wb) * SUM_W'(r_s2_b)
              + SUM_W'(r_wc) * SUM_W'(r_s2_c) + SUM_W'(r_wd) * SUM_W'(r_s2_d);
        w_rnd = w_sum + HALF;
        w_res = w_rnd >> (2 * FRAC_W);
        w_pix = (w_res > PIX_MAX) ? PIX_W'(PIX_MAX) : PIX_W'(w_res);
    end

    // S3: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_pix   <= '0;
            r_m_zero  <= 1'b1;
        end else if (w_en) begin
            r_m_valid <= r_s2_vld;
            if (r_s2_vld) begin
                r_m_pix  <= w_pix;
                r_m_zero <= (w_pix == '0);
            end
        end
    end
endmodule

// File: tb/tb_bilinear_interp_pipe.sv
// Directed vectors, random burst, backpressure, config hazard and reset checks.
module tb_bilinear_interp_pipe;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned R_W    = 3;
    localparam int unsigned ANG_W  = 2;
    localparam int unsigned DEPTH  = 1 << (R_W + ANG_W);

    typedef struct {
        logic [PIX_W-1:0] pix;
        logic             zero;
    } exp_t;

    typedef struct {
        bit          we;
        logic [4:0]  addr;
        logic [7:0]  dx;
        logic [7:0]  dy;
        logic [2:0]  r;
        logic [1:0]  ang;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [7:0]  d;
        logic [7:0]  pix;
        logic        zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   n_acc  = 0;
    int   n_out  = 0;
    int   cyc    = 0;

    exp_t exp_q[$];
    int   mdl_dx [DEPTH];
    int   mdl_dy [DEPTH];
    bit   hold_vld = 1'b0;
    logic [PIX_W-1:0] hold_pix = '0;

    bilinear_interp_pipe_if #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .R_W(R_W), .ANG_W(ANG_W)) bus ();

    bilinear_interp_pipe #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .R_W(R_W), .ANG_W(ANG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Interpolation as plain arithmetic on the weight definitions.
    function automatic exp_t ref_model(input int a, input int b, input int c, input int d,
                                       input int dx, input int dy);
        longint one, s, q;
        exp_t   e;
        one = longint'(1) << FRAC_W;
        s = (one - dx) * (one - dy) * a + dx * (one - dy) * b
          + (one - dx) * dy * c + dx * dy * d;
        q = (s + (one * one) / 2) / (one * one);
        if (q > 255) q = 255;
        e.pix  = 8'(q);
        e.zero = (q == 0);
        return e;
    endfunction

    // Monitor: scoreboard on handshakes, hold stability, ready rule, table model.
    always @(negedge clk) begin
        exp_t e;
        int   addr;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) begin
                mdl_dx[i] = 0;
                mdl_dy[i] = 0;
            end
            hold_vld = 1'b0;
        end else begin
            chk("s_ready_rule", bus.s_ready, (!bus.m_valid || bus.m_ready));
            if (hold_vld) begin
                chk("hold_valid", bus.m_valid, 1);
                chk("hold_pix", bus.m_pix, hold_pix);
            end
            if (bus.m_valid && bus.m_ready) begin
                n_out++;
                chk("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_pix", bus.m_pix, e.pix);
                    chk("sb_zero", bus.m_zero, e.zero);
                end
            end
            hold_vld = bus.m_valid && !bus.m_ready;
            hold_pix = bus.m_pix;
            if (bus.s_valid && bus.s_ready) begin
                n_acc++;
                addr = int'({bus.s_r, bus.s_angle});
                exp_q.push_back(ref_model(bus.s_a, bus.s_b, bus.s_c, bus.s_d,
                                          mdl_dx[addr], mdl_dy[addr]));
            end
            if (bus.cfg_we) begin
                mdl_dx[bus.cfg_addr] = bus.cfg_dx;
                mdl_dy[bus.cfg_addr] = bus.cfg_dy;
            end
        end
    end

    task automatic idle();
        bus.s_valid = 1'b0;
        bus.s_r     = 3'($urandom);
        bus.s_angle = 2'($urandom);
        bus.s_a     = 8'($urandom);
        bus.s_b     = 8'($urandom);
        bus.s_c     = 8'($urandom);
        bus.s_d     = 8'($urandom);
    endtask

    task automatic cfg_write(input logic [4:0] addr, input logic [7:0] dx, input logic [7:0] dy);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_dx   = dx;
        bus.cfg_dy   = dy;
        @(posedge clk); #1;
        bus.cfg_we   = 1'b0;
    endtask

    // Present one sample and hold it until accepted (bounded).
    task automatic send(input logic [2:0] r, input logic [1:0] ang,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
        bit ok;
        bus.s_valid = 1'b1;
        bus.s_r     = r;
        bus.s_angle = ang;
        bus.s_a     = a;
        bus.s_b     = b;
        bus.s_c     = c;
        bus.s_d     = d;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk); #1;
        end
        chk("accept", ok, 1);
    endtask

    // Cycles from the accepting edge until m_valid shows (1 = right after that edge).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.m_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    vec_t vecs[6];

    initial begin
        int lat, acc0, out0, t0, stale;

        vecs[0] = '{1'b0, 5'd0,  8'h00, 8'h00, 3'd0, 2'd0, 8'h37, 8'hFF, 8'hFF, 8'hFF, 8'h37, 1'b0};
        vecs[1] = '{1'b1, 5'd4,  8'h80, 8'h80, 3'd1, 2'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd25, 1'b0};
        vecs[2] = '{1'b1, 5'd5,  8'h80, 8'h00, 3'd1, 2'd1, 8'd1,  8'd2,  8'd0,  8'd0,  8'd2,  1'b0};
        vecs[3] = '{1'b0, 5'd5,  8'h00, 8'h00, 3'd1, 2'd1, 8'd0,  8'd1,  8'd0,  8'd0,  8'd1,  1'b0};
        vecs[4] = '{1'b0, 5'd5,  8'h00, 8'h00, 3'd1, 2'd1, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  1'b1};
        vecs[5] = '{1'b1, 5'd14, 8'h55, 8'hAA, 3'd3, 2'd2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0};

        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_dx   = '0;
        bus.cfg_dy   = '0;
        bus.m_ready  = 1'b1;
        idle();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_pix", bus.m_pix, 0);
        chk("rst_m_zero", bus.m_zero, 1);
        rst = 1'b0;
        chk("rst_s_ready", bus.s_ready, 1);

        // Directed vectors, pipeline drained between each.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].we) cfg_write(vecs[i].addr, vecs[i].dx, vecs[i].dy);
            send(vecs[i].r, vecs[i].ang, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
            idle();
            wait_valid(lat);
            chk($sformatf("vec%0d_latency", i), lat, 3);
            chk($sformatf("vec%0d_pix", i), bus.m_pix, vecs[i].pix);
            chk($sformatf("vec%0d_zero", i), bus.m_zero, vecs[i].zero);
            @(posedge clk); #1;
        end

        // Random table and a back-to-back burst of 64 samples.
        for (int i = 0; i < DEPTH; i++) cfg_write(5'(i), 8'($urandom), 8'($urandom));
        out0 = n_out;
        t0   = cyc;
        for (int i = 0; i < 64; i++)
            send(3'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        chk("burst_cycles", cyc - t0, 64);
        idle();
        repeat (6) @(posedge clk);
        #1;
        chk("burst_outputs", n_out - out0, 64);

        // Backpressure: consumer stalls for 6 cycles while 5 samples are offered.
        out0 = n_out;
        acc0 = n_acc;
        bus.m_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(3'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                idle();
            end
            begin
                repeat (6) @(posedge clk);
                chk("bp_accepted_in_stall", n_acc - acc0, 3);
                #1;
                bus.m_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        chk("bp_outputs", n_out - out0, 5);

        // Config hazard: write {2,1} in the same cycle a sample at {2,1} is accepted.
        cfg_write(5'd9, 8'h00, 8'h00);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 5'd9;
        bus.cfg_dx   = 8'h80;
        bus.cfg_dy   = 8'h80;
        send(3'd2, 2'd1, 8'd10, 8'd20, 8'd30, 8'd40);
        bus.cfg_we   = 1'b0;
        send(3'd2, 2'd1, 8'd10, 8'd20, 8'd30, 8'd40);
        idle();
        wait_valid(lat);
        chk("hazard_old_valid", bus.m_valid, 1);
        chk("hazard_old_pix", bus.m_pix, 10);
        @(posedge clk); #1;
        chk("hazard_new_valid", bus.m_valid, 1);
        chk("hazard_new_pix", bus.m_pix, 25);
        repeat (3) @(posedge clk);
        #1;

        // Reset with two samples in flight.
        send(3'd1, 2'd0, 8'd90, 8'd91, 8'd92, 8'd93);
        send(3'd1, 2'd0, 8'd94, 8'd95, 8'd96, 8'd97);
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        chk("midrst_m_valid", bus.m_valid, 0);
        chk("midrst_m_zero", bus.m_zero, 1);
        rst = 1'b0;
        chk("midrst_s_ready", bus.s_ready, 1);
        stale = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.m_valid) stale++;
        end
        chk("midrst_stale_outputs", stale, 0);
        send(3'd1, 2'd0, 8'h37, 8'hFF, 8'hFF, 8'hFF);
        idle();
        wait_valid(lat);
        chk("cleared_table_latency", lat, 3);
        chk("cleared_table_pix", bus.m_pix, 8'h37);
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
